// File: rtl/band_peak_reader_pkg.sv
// Shared types and constants for the band peak reader.
// AUDIO_LEVEL_EN adds an eighth channel (band 7) derived from the audio sample.
package band_pkg;

  localparam int NUM_BANDS = 7;
  localparam int LEVEL_W   = 8;
  localparam int IDX_W     = 3;
  localparam int AUDIO_W   = 18;

`ifdef AUDIO_LEVEL_EN
  localparam int FRAME_LEN = NUM_BANDS + 1;
`else
  localparam int FRAME_LEN = NUM_BANDS;
`endif

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  typedef logic [LEVEL_W-1:0] level_t;

  // One entry per channel carried in a frame.
  typedef level_t [FRAME_LEN-1:0] level_arr_t;

  // |sample| bits [16:9]; the most negative sample saturates to full scale
  // instead of wrapping back to zero.
  function automatic level_t audio_level(input logic signed [AUDIO_W-1:0] sample);
    logic [AUDIO_W-1:0] mag;
    mag = sample[AUDIO_W-1] ? $unsigned(-sample) : $unsigned(sample);
    if (mag[AUDIO_W-1]) begin
      return '1;
    end
    return mag[16:9];
  endfunction

endpackage

// File: rtl/band_peak_reader_if.sv
// Beat stream from the band peak reader to the display/visualiser logic.
interface band_peak_reader_if;
  import band_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_band;
  level_t           out_level;
  logic             out_first;

  modport master (
    output out_valid,
    output out_band,
    output out_level,
    output out_first,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_band,
    input  out_level,
    input  out_first,
    output out_ready
  );

endinterface

// File: rtl/band_peak_reader_cell.sv
// Single-channel peak-hold register with hold counter and linear decay.
module peak_hold_cell
  import band_pkg::*;
#(
  parameter int HOLD_SAMPLES = 48,
  parameter int DECAY_STEP   = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   cap,
  input  level_t level,
  output level_t peak,
  output level_t peak_next
);

  logic [7:0] hold;
  logic [7:0] hold_next;
  logic [8:0] decayed;

  // Nine-bit difference so a step larger than the peak shows up as a borrow.
  assign decayed = {1'b0, peak} - 9'(DECAY_STEP);

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    peak_next = peak;
    hold_next = hold;
    if (cap) begin
      if (level >= peak) begin
        peak_next = level;
        hold_next = 8'(HOLD_SAMPLES);
      end else if (hold != '0) begin
        hold_next = hold - 8'd1;
      end else if (decayed[8]) begin
        peak_next = level;
      end else begin
        peak_next = (decayed[7:0] > level) ? decayed[7:0] : level;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak <= '0;
      hold <= '0;
    end else begin
      peak <= peak_next;
      hold <= hold_next;
    end
  end

endmodule

// File: rtl/band_peak_reader.sv
// Samples the seven band levels after each audio strobe, applies peak-hold
// with decay and streams each frame as beats. Optional macro: AUDIO_LEVEL_EN.
module band_peak_reader
  import band_pkg::*;
#(
  parameter int HOLD_SAMPLES = 48,
  parameter int DECAY_STEP   = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ready,
  input  logic signed [AUDIO_W-1:0] audio_out,
  input  level_t                    freq1,
  input  level_t                    freq2,
  input  level_t                    freq3,
  input  level_t                    freq4,
  input  level_t                    freq5,
  input  level_t                    freq6,
  input  level_t                    freq7,
  band_peak_reader_if.master        bus,
  output logic                      overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic             cap;
  level_arr_t       levels;
  level_arr_t       peaks;
  level_arr_t       peaks_next;
  level_arr_t       snap;
  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic             pending;
  logic             pending_next;
  logic             take_snap;
  logic             overrun_set;
  logic             beat_xfer;

  assign levels[0] = freq1;
  assign levels[1] = freq2;
  assign levels[2] = freq3;
  assign levels[3] = freq4;
  assign levels[4] = freq5;
  assign levels[5] = freq6;
  assign levels[6] = freq7;

`ifdef AUDIO_LEVEL_EN
  assign levels[NUM_BANDS] = audio_level(audio_out);
`else
  logic unused_audio;
  assign unused_audio = ^audio_out;
`endif

  // Band values settle one clock after the strobe, so capture on the delayed copy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cap <= 1'b0;
    end else begin
      cap <= ready;
    end
  end

  for (genvar g = 0; g < FRAME_LEN; g++) begin : g_cell
    peak_hold_cell #(
      .HOLD_SAMPLES (HOLD_SAMPLES),
      .DECAY_STEP   (DECAY_STEP)
    ) u_cell (
      .clk       (clock),
      .rst_n     (reset),
      .cap       (cap),
      .level     (levels[g]),
      .peak      (peaks[g]),
      .peak_next (peaks_next[g])
    );
  end

  assign beat_xfer = (state == SEND) && bus.out_ready;

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    pending_next = pending;
    take_snap    = 1'b0;
    overrun_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cap) begin
          take_snap  = 1'b1;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        // A capture already queued cannot be queued twice; the newer one is lost.
        if (cap && pending) begin
          overrun_set = 1'b1;
        end
        if (beat_xfer && (idx == LAST_IDX)) begin
          if (pending || cap) begin
            take_snap    = 1'b1;
            idx_next     = '0;
            pending_next = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          if (beat_xfer) begin
            idx_next = idx + 1'b1;
          end
          if (cap) begin
            pending_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Snapshot uses post-update peaks so a capture on the restart cycle is included.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      pending <= 1'b0;
      snap    <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      pending <= pending_next;
      if (take_snap) begin
        snap <= peaks_next;
      end
      if (overrun_set) begin
        overrun <= 1'b1;
      end
    end
  end

  assign bus.out_valid = (state == SEND);
  assign bus.out_band  = (state == SEND) ? idx : '0;
  assign bus.out_level = (state == SEND) ? snap[idx] : '0;
  assign bus.out_first = (state == SEND) && (idx == '0);

endmodule
